// File: rtl/divmod_seq_unit.sv
// ============================================================================
// Module  : divmod_seq_unit
// Brief   : Multi-cycle restoring divider, quotient and remainder together.
//           Define DIVMOD_SIGNED_EN to add the signed_mode operand option.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divmod_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIVMOD_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] dq_q,      dq_d;
  logic [WIDTH-1:0] dvs_q,     dvs_d;
  logic             zero_q,    zero_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q,     quo_d;
  logic [WIDTH-1:0] rmd_q,     rmd_d;
  logic             dbz_q,     dbz_d;

  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_dvd_orig;

`ifdef DIVMOD_SIGNED_EN
  assign w_sgn = signed_mode;
`else
  assign w_sgn = 1'b0;
`endif

  assign w_a_neg = w_sgn & dividend[WIDTH-1];
  assign w_b_neg = w_sgn & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // dq_q holds the remaining dividend bits at the top and collects
  // quotient bits at the bottom as the iteration proceeds.
  assign w_shift    = {rem_q, dq_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, dvs_q};
  assign w_ge       = (w_shift >= {1'b0, dvs_q});
  assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_step = {dq_q[WIDTH-2:0], w_ge};

  assign w_quo_fix  = neg_quo_q ? (~w_quo_step + 1'b1) : w_quo_step;
  assign w_rem_fix  = neg_rem_q ? (~w_rem_step + 1'b1) : w_rem_step;
  assign w_dvd_orig = neg_rem_q ? (~dq_q + 1'b1) : dq_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    zero_d    = zero_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dq_d      = w_a_mag;
          dvs_d     = w_b_mag;
          rem_d     = '0;
          zero_d    = (divisor == '0);
          cnt_d     = (divisor == '0) ? CW'(1) : CW'(WIDTH);
          neg_quo_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // A zero divisor spends a single RUN cycle so done arrives one
        // edge after acceptance, like a one-bit division would.
        if (zero_q) begin
          quo_d   = '1;
          rmd_d   = w_dvd_orig;
          dbz_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          rem_d = w_rem_step;
          dq_d  = w_quo_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_d   = w_quo_fix;
            rmd_d   = w_rem_fix;
            dbz_d   = 1'b0;
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      zero_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      zero_q    <= zero_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_divmod_seq_unit.sv
// ============================================================================
// Module  : tb_divmod_seq_unit
// Brief   : Scoreboard bench for divmod_seq_unit with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divmod_seq_unit;

  localparam int W = 32;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
`ifdef DIVMOD_SIGNED_EN
  logic         signed_mode = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  logic prev_done = 1'b0;

  divmod_seq_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef DIVMOD_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (done) begin
      chk("done_single_cycle", {{(W-1){1'b0}}, prev_done}, '0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with q=0x%0h r=0x%0h, expected none", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient",    quotient, e.q);
        chk("remainder",   remainder, e.r);
        chk("div_by_zero", {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, e.dbz});
        chk("latency",     W'(cyc - e.acc), W'(e.lat));
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int acc);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.acc = acc;
    e.lat = edbz ? 1 : W;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
    push_exp(eq, er, edbz, cyc);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, expected idle with none pending",
               name, busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    issue(a, b, eq, er, edbz);
    wait_idle("op");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {{(W-1){1'b0}}, busy}, '0);
    chk({tag, "_done"}, {{(W-1){1'b0}}, done}, '0);
    chk({tag, "_q"},    quotient, '0);
    chk({tag, "_r"},    remainder, '0);
    chk({tag, "_dbz"},  {{(W-1){1'b0}}, div_by_zero}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    chk("dbz_held", {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, 1'b1});
    run(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);

    // Start pulse during RUN must be dropped, not queued.
    issue(32'd200, 32'd3, 32'd66, 32'd2, 1'b0);
    repeat (10) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("held_during_run", remainder, 32'd3);
    wait_idle("ignored_start");
    repeat (3) @(negedge clk);
    chk("not_queued_busy", {{(W-1){1'b0}}, busy}, '0);
    chk("held_q", quotient, 32'd66);
    chk("held_r", remainder, 32'd2);

    run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);
    run(32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0);

    // Start held high: second op accepted WIDTH+2 edges after the first.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc0 = cyc;
    push_exp(32'd100, 32'd0, 1'b0, acc0);
    push_exp(32'd15, 32'd2, 1'b0, acc0 + W + 2);
    dividend = 32'd77;
    divisor  = 32'd5;
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("back_to_back");

    // Asynchronous reset in the middle of an operation.
    issue(32'hDEAD_BEEF, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);

`ifdef DIVMOD_SIGNED_EN
    signed_mode = 1'b1;
    run(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run(32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
    signed_mode = 1'b0;
    run(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
